// File: rtl/debounce_pkg.sv
// Shared constants and width helpers for the multi-channel debouncer.
// Repeat feature is enabled by defining DEBOUNCE_REPEAT_EN.
package debounce_pkg;

  localparam int unsigned DefaultTickHz      = 1000;
  localparam int unsigned DefaultStableTicks = 25;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int unsigned width_for(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Shared prescaler: one-cycle tick every DIV clocks (every clock when DIV == 1).
module tick_gen
  import debounce_pkg::*;
#(
  parameter int unsigned DIV = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned W = width_for(DIV - 1);

  logic [W-1:0] count_q;

  assign tick = (count_q == W'(DIV - 1));

  always_ff @(posedge clk) begin
    if (rst || tick) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + W'(1);
    end
  end

endmodule

// File: rtl/multi_debounce.sv
// N-channel debouncer: 2-FF sync, tick-driven stability counter, level and edge pulses.
// Define DEBOUNCE_REPEAT_EN to add per-channel auto-repeat on held inputs.
module multi_debounce
  import debounce_pkg::*;
#(
  parameter int unsigned CHANNELS            = 4,
  parameter int unsigned CLK_HZ              = 100_000_000,
  parameter int unsigned TICK_HZ             = DefaultTickHz,
  parameter int unsigned STABLE_TICKS        = DefaultStableTicks,
  parameter int unsigned REPEAT_DELAY_TICKS  = 500,
  parameter int unsigned REPEAT_PERIOD_TICKS = 100
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] btn,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall,
  output logic [CHANNELS-1:0] rpt
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned CW  = $clog2(STABLE_TICKS + 1);

  if (DIV == 0 || STABLE_TICKS == 0 || REPEAT_DELAY_TICKS == 0 ||
      REPEAT_PERIOD_TICKS == 0) begin : g_cfg_err
    $error("multi_debounce: invalid parameter set");
  end

  logic tick;

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    logic          s1_q, s2_q;
    logic          level_q, rise_q, fall_q;
    logic [CW-1:0] cnt_q;
    logic          take;

    // Level flips on this tick: input has differed for the full window.
    assign take = tick && (s2_q != level_q) && (cnt_q == CW'(STABLE_TICKS - 1));

    always_ff @(posedge clk) begin
      if (rst) begin
        s1_q    <= 1'b0;
        s2_q    <= 1'b0;
        level_q <= 1'b0;
        rise_q  <= 1'b0;
        fall_q  <= 1'b0;
        cnt_q   <= '0;
      end else begin
        s1_q   <= btn[i];
        s2_q   <= s1_q;
        rise_q <= 1'b0;
        fall_q <= 1'b0;
        if (tick) begin
          if (s2_q == level_q) begin
            cnt_q <= '0;
          end else if (take) begin
            level_q <= s2_q;
            cnt_q   <= '0;
            rise_q  <= s2_q;
            fall_q  <= ~s2_q;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
      end
    end

    assign level[i] = level_q;
    assign rise[i]  = rise_q;
    assign fall[i]  = fall_q;

`ifdef DEBOUNCE_REPEAT_EN
    localparam int unsigned HW = width_for(max_u(REPEAT_DELAY_TICKS, REPEAT_PERIOD_TICKS));

    logic [HW-1:0] hcnt_q;
    logic          rep_q, rpt_q;
    logic [HW-1:0] target;

    // First pulse waits the delay; later pulses use the period.
    assign target = rep_q ? HW'(REPEAT_PERIOD_TICKS) : HW'(REPEAT_DELAY_TICKS);

    always_ff @(posedge clk) begin
      if (rst || !level_q || take) begin
        hcnt_q <= '0;
        rep_q  <= 1'b0;
        rpt_q  <= 1'b0;
      end else begin
        rpt_q <= 1'b0;
        if (tick) begin
          if (hcnt_q + HW'(1) == target) begin
            hcnt_q <= '0;
            rep_q  <= 1'b1;
            rpt_q  <= 1'b1;
          end else begin
            hcnt_q <= hcnt_q + HW'(1);
          end
        end
      end
    end

    assign rpt[i] = rpt_q;
`else
    assign rpt[i] = 1'b0;
`endif
  end

endmodule
